// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for RAM port B: the core has default priority, and the DMA master is
// guaranteed a slot after MAX_STREAK back-to-back core grants. Read data is steered by rd_owner.
module ram_port_arbiter #(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        core_en_i,
    input  logic [3:0]  core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_data_i,
    output logic        core_stall_o,
    output logic [31:0] core_data_o,

    input  logic        dma_req_i,
    input  logic [3:0]  dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_data_i,
    output logic        dma_gnt_o,
    output logic        dma_rvalid_o,
    output logic [31:0] dma_data_o,

    output logic        ram_en_o,
    output logic [3:0]  ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    localparam logic [3:0] StreakMax = 4'(MAX_STREAK);

    typedef enum logic [1:0] {
        OwnNone,
        OwnCore,
        OwnDma
    } owner_e;

    logic [3:0] streak_q, streak_d;
    owner_e     rd_owner_q, rd_owner_d;
    logic       dma_win, core_win;

    // Grant decision; reset forces every grant off.
    always_comb begin
        dma_win  = 1'b0;
        core_win = 1'b0;
        if (!reset) begin
            dma_win  = dma_req_i && (!core_en_i || (streak_q == StreakMax));
            core_win = core_en_i && !dma_win;
        end
    end

    always_comb begin
        ram_en_o     = dma_win || core_win;
        ram_we_o     = 4'b0;
        ram_addr_o   = core_addr_i;
        ram_data_o   = core_data_i;
        dma_gnt_o    = dma_win;
        core_stall_o = dma_win && core_en_i;
        if (dma_win) begin
            ram_we_o   = dma_we_i;
            ram_addr_o = dma_addr_i;
            ram_data_o = dma_data_i;
        end else if (core_win) begin
            ram_we_o = core_we_i;
        end
    end

    always_comb begin
        streak_d   = streak_q;
        rd_owner_d = OwnNone;
        if (dma_win || !dma_req_i) begin
            streak_d = 4'd0;
        end else if (core_win) begin
            streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 4'd1;
        end
        if (core_win && (core_we_i == 4'b0)) begin
            rd_owner_d = OwnCore;
        end else if (dma_win && (dma_we_i == 4'b0)) begin
            rd_owner_d = OwnDma;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q   <= 4'd0;
            rd_owner_q <= OwnNone;
        end else begin
            streak_q   <= streak_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // A read in flight when reset rises is dropped, hence the reset gate.
    always_comb begin
        core_data_o  = ram_data_i;
        dma_rvalid_o = !reset && (rd_owner_q == OwnDma);
        dma_data_o   = dma_rvalid_o ? ram_data_i : 32'd0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a byte-addressed RAM model on port B, a shadow-memory reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_ram_port_arbiter;

    localparam int unsigned MaxStreak = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_en_i;
    logic [3:0]  core_we_i;
    logic [31:0] core_addr_i, core_data_i;
    logic        core_stall_o;
    logic [31:0] core_data_o;
    logic        dma_req_i;
    logic [3:0]  dma_we_i;
    logic [31:0] dma_addr_i, dma_data_i;
    logic        dma_gnt_o, dma_rvalid_o;
    logic [31:0] dma_data_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o;
    logic [31:0] ram_data_i;

    ram_port_arbiter #(.MAX_STREAK(MaxStreak)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_en_i    (core_en_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_data_i  (core_data_i),
        .core_stall_o (core_stall_o),
        .core_data_o  (core_data_o),
        .dma_req_i    (dma_req_i),
        .dma_we_i     (dma_we_i),
        .dma_addr_i   (dma_addr_i),
        .dma_data_i   (dma_data_i),
        .dma_gnt_o    (dma_gnt_o),
        .dma_rvalid_o (dma_rvalid_o),
        .dma_data_o   (dma_data_o),
        .ram_en_o     (ram_en_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_data_o   (ram_data_o),
        .ram_data_i   (ram_data_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] pattern(int i);
        if (i == 128) return 32'h1234_5678;
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // RAM on port B: one-cycle read latency, byte-enabled writes.
    logic [31:0] ram [256];
    bit ram_init_done = 1'b0;

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 256; i++) ram[i] <= pattern(i);
            ram_data_i    <= 32'd0;
            ram_init_done <= 1'b1;
        end else if (ram_en_o) begin
            if (ram_we_o == 4'b0) begin
                ram_data_i <= ram[ram_addr_o[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we_o[b]) ram[ram_addr_o[9:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
            end
        end
    end

    // Reference model: who should own the port, and what each master should see back.
    logic [31:0] shadow [256];

    initial begin
        int          waited;
        bit          gd, gc, pend_dma, pend_core;
        logic [31:0] pend_dma_data, pend_core_data;
        waited    = 0;
        pend_dma  = 1'b0;
        pend_core = 1'b0;
        pend_dma_data  = '0;
        pend_core_data = '0;
        for (int i = 0; i < 256; i++) shadow[i] = pattern(i);
        forever begin
            @(negedge clk);
            gd = 1'b0;
            gc = 1'b0;
            if (!reset) begin
                gd = dma_req_i && (!core_en_i || waited >= int'(MaxStreak));
                gc = core_en_i && !gd;
            end
            check("ram_en", 32'(ram_en_o), 32'(gd || gc));
            check("ram_we", 32'(ram_we_o), gd ? 32'(dma_we_i) : (gc ? 32'(core_we_i) : 32'd0));
            if (gd || gc) check("ram_addr", ram_addr_o, gd ? dma_addr_i : core_addr_i);
            if (gd && dma_we_i != 0) check("ram_wdata", ram_data_o, dma_data_i);
            if (gc && core_we_i != 0) check("ram_wdata", ram_data_o, core_data_i);
            check("dma_gnt", 32'(dma_gnt_o), 32'(gd));
            check("core_stall", 32'(core_stall_o), 32'(gd && core_en_i));
            check("dma_rvalid", 32'(dma_rvalid_o), 32'(!reset && pend_dma));
            check("dma_data", dma_data_o, (!reset && pend_dma) ? pend_dma_data : 32'd0);
            if (pend_core) check("core_data", core_data_o, pend_core_data);
            @(posedge clk);
            if (reset) begin
                waited    = 0;
                pend_dma  = 1'b0;
                pend_core = 1'b0;
            end else begin
                pend_dma  = gd && (dma_we_i == 0);
                pend_core = gc && (core_we_i == 0);
                if (pend_dma) pend_dma_data = shadow[dma_addr_i[9:2]];
                if (pend_core) pend_core_data = shadow[core_addr_i[9:2]];
                for (int b = 0; b < 4; b++) begin
                    if (gd && dma_we_i[b]) shadow[dma_addr_i[9:2]][8*b +: 8] = dma_data_i[8*b +: 8];
                    if (gc && core_we_i[b])
                        shadow[core_addr_i[9:2]][8*b +: 8] = core_data_i[8*b +: 8];
                end
                if (gd || !dma_req_i) waited = 0;
                else if (gc && waited < int'(MaxStreak)) waited = waited + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_set(logic en, logic [3:0] we, logic [31:0] addr, logic [31:0] data);
        core_en_i   = en;
        core_we_i   = we;
        core_addr_i = addr;
        core_data_i = data;
    endtask

    task automatic dma_set(logic req, logic [3:0] we, logic [31:0] addr, logic [31:0] data);
        dma_req_i  = req;
        dma_we_i   = we;
        dma_addr_i = addr;
        dma_data_i = data;
    endtask

    initial begin
        reset = 1'b1;
        core_set(1'b1, 4'h0, 32'h0000_0100, 32'd0);
        dma_set(1'b1, 4'h0, 32'h0000_0200, 32'd0);

        // Reset holds every grant off even with both masters requesting.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ram_en", 32'(ram_en_o), 32'd0);
            check("rst_dma_gnt", 32'(dma_gnt_o), 32'd0);
            check("rst_stall", 32'(core_stall_o), 32'd0);
            check("rst_rvalid", 32'(dma_rvalid_o), 32'd0);
        end

        // Release: core wins first; core write then read-back, plus a partial write.
        step();
        reset = 1'b0;
        core_set(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
        #1;
        check("first_gnt_core", 32'(dma_gnt_o), 32'd0);
        check("first_ram_addr", ram_addr_o, 32'h0000_0100);
        step();
        dma_set(1'b0, 4'h0, 32'h0, 32'h0);
        core_set(1'b1, 4'h0, 32'h0000_0100, 32'd0);
        #1;
        check("core_rd_stall", 32'(core_stall_o), 32'd0);
        check("core_rd_we", 32'(ram_we_o), 32'd0);
        step();
        core_set(1'b1, 4'b0011, 32'h0000_0020, 32'hFFFF_FFFF);
        #1;
        check("core_rdata", core_data_o, 32'hDEAD_BEEF);
        step();
        core_set(1'b1, 4'h0, 32'h0000_0020, 32'd0);
        step();
        core_set(1'b0, 4'h0, 32'h0, 32'd0);
        #1;
        check("core_partial", core_data_o, 32'hC0DE_FFFF);

        // DMA alone: grant in N, data in N+1, nothing in N+2.
        step();
        dma_set(1'b1, 4'h0, 32'h0000_0200, 32'd0);
        #1;
        check("dma_gnt_n", 32'(dma_gnt_o), 32'd1);
        step();
        dma_set(1'b0, 4'h0, 32'h0, 32'd0);
        #1;
        check("dma_rvalid_n1", 32'(dma_rvalid_o), 32'd1);
        check("dma_data_n1", dma_data_o, 32'h1234_5678);
        step();
        check("dma_rvalid_n2", 32'(dma_rvalid_o), 32'd0);

        // Contention: DMA waits through MaxStreak core grants.
        for (int c = 0; c < 7; c++) begin
            step();
            core_set(1'b1, 4'h0, 32'h0000_0008, 32'd0);
            dma_set(c <= 4, 4'h0, 32'h0000_0204, 32'd0);
            #1;
            check("cont_dma_gnt", 32'(dma_gnt_o), 32'(c == 4));
            check("cont_stall", 32'(core_stall_o), 32'(c == 4));
        end

        // Simultaneous writes: core first, DMA next cycle.
        step();
        core_set(1'b1, 4'hF, 32'h0000_0010, 32'h0000_000A);
        dma_set(1'b1, 4'hF, 32'h0000_0014, 32'h0000_000B);
        #1;
        check("wr_first_addr", ram_addr_o, 32'h0000_0010);
        check("wr_first_gnt", 32'(dma_gnt_o), 32'd0);
        step();
        core_set(1'b0, 4'h0, 32'h0, 32'd0);
        #1;
        check("wr_second_gnt", 32'(dma_gnt_o), 32'd1);
        check("wr_second_addr", ram_addr_o, 32'h0000_0014);
        step();
        dma_set(1'b0, 4'h0, 32'h0, 32'd0);
        step();
        check("ram_0x10", ram[4], 32'h0000_000A);
        check("ram_0x14", ram[5], 32'h0000_000B);

        // Reset between a DMA read grant and its return drops the data.
        dma_set(1'b1, 4'h0, 32'h0000_0200, 32'd0);
        #1;
        check("rr_gnt", 32'(dma_gnt_o), 32'd1);
        step();
        reset = 1'b1;
        dma_set(1'b0, 4'h0, 32'h0, 32'd0);
        #1;
        check("rr_rvalid_rst", 32'(dma_rvalid_o), 32'd0);
        check("rr_data_rst", dma_data_o, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rr_rvalid_after", 32'(dma_rvalid_o), 32'd0);

        // Streak restarted from zero: DMA again waits MaxStreak core grants.
        for (int c = 0; c < 6; c++) begin
            step();
            core_set(1'b1, 4'h0, 32'h0000_000C, 32'd0);
            dma_set(c <= 4, 4'h0, 32'h0000_0208, 32'd0);
            #1;
            check("post_rst_gnt", 32'(dma_gnt_o), 32'(c == 4));
        end

        step();
        core_set(1'b0, 4'h0, 32'h0, 32'd0);
        dma_set(1'b0, 4'h0, 32'h0, 32'd0);
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
